// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM arbiter slice.
package sram_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Timeout counter width; keeps one bit even when the timeout is disabled.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester, SRAM and status signals of the arbiter; slave = arbiter view, master = environment view.
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wr_data;
    logic [NUM_REQ-1:0]             req_wr_rd;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_rdata;
    logic                           rsp_err;
    logic [ADDR_W-1:0]              mem_addr;
    logic [DATA_W-1:0]              mem_wr_data;
    logic                           mem_wr_rd;
    logic                           mem_valid;
    logic                           mem_ready;
    logic [DATA_W-1:0]              mem_rd_data;
    logic                           busy;
    logic [$clog2(NUM_REQ)-1:0]     grant_id;

    modport slave (
        input  req_valid, req_addr, req_wr_data, req_wr_rd, mem_ready, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wr_data, mem_wr_rd, mem_valid, busy, grant_id
    );

    modport master (
        output req_valid, req_addr, req_wr_data, req_wr_rd, mem_ready, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wr_data, mem_wr_rd, mem_valid, busy, grant_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant_i, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    int cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_grant_i) + i) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                grant_o[cand]  = 1'b1;
                grant_idx_o    = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port among NUM_REQ requesters,
// one transaction at a time with optional BUSY timeout.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    sram_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   last_grant_q, grant_id_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q, rdata_q;
    logic               wr_q, err_q, mem_valid_q, busy_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any, accept, expire;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i       (bus.req_valid),
        .last_grant_i(last_grant_q),
        .grant_o     (win_oh),
        .grant_idx_o (win_idx),
        .any_o       (win_any)
    );

    assign accept = (state_q == IDLE) && win_any && !rst;
    // Expires on the TIMEOUT-th BUSY cycle; counter holds BUSY cycles already elapsed.
    assign expire = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mem_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        addr_q       <= bus.req_addr[win_idx];
                        wdata_q      <= bus.req_wr_data[win_idx];
                        wr_q         <= bus.req_wr_rd[win_idx];
                        grant_id_q   <= win_idx;
                        last_grant_q <= win_idx;
                        cnt_q        <= '0;
                        mem_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    // mem_ready wins over an expiring timeout.
                    if (bus.mem_ready || expire) begin
                        rdata_q     <= (bus.mem_ready && !wr_q) ? bus.mem_rd_data : '0;
                        err_q       <= !bus.mem_ready;
                        mem_valid_q <= 1'b0;
                        rsp_valid_q <= NUM_REQ'(1) << grant_id_q;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = accept ? win_oh : '0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wdata_q;
    assign bus.mem_wr_rd   = wr_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: read, round-robin, write, timeout edge cases, mid-BUSY reset.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_mv;
    logic got_rsp, saw_rsp;

    sram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_wr_data = '0;
        bus.req_wr_rd   = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_rd_data = '0;

        // reset: outputs quiet even with requests pending
        cyc();
        bus.req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
        chk("rst_grant_id",  32'(bus.grant_id),  32'h0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        cyc();
        rst = 1'b0;
        bus.req_valid = '0;

        // single read, requester 2, mem_ready 3 cycles after mem_valid
        bus.req_valid   = 4'b0100;
        bus.req_addr[2] = 8'h3C;
        #1;
        chk("rd_accept", 32'(bus.req_ready), 32'h4);
        cyc();
        bus.req_valid = '0;
        chk("rd_busy",      32'(bus.busy),      32'h1);
        chk("rd_mem_valid", 32'(bus.mem_valid), 32'h1);
        chk("rd_mem_addr",  32'(bus.mem_addr),  32'h3C);
        chk("rd_mem_wr_rd", 32'(bus.mem_wr_rd), 32'h0);
        chk("rd_grant_id",  32'(bus.grant_id),  32'h2);
        cyc();
        chk("rd_mv_t2", 32'(bus.mem_valid), 32'h1);
        cyc();
        chk("rd_no_rsp_t3", 32'(bus.rsp_valid), 32'h0);
        cyc();
        bus.mem_ready   = 1'b1;
        bus.mem_rd_data = 16'hBEEF;
        cyc();
        bus.mem_ready   = 1'b0;
        bus.mem_rd_data = '0;
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        chk("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'hBEEF);
        chk("rd_rsp_err",   32'(bus.rsp_err),   32'h0);
        chk("rd_mv_drop",   32'(bus.mem_valid), 32'h0);
        cyc();
        chk("rd_rsp_pulse", 32'(bus.rsp_valid), 32'h0);
        chk("rd_idle",      32'(bus.busy),      32'h0);

        // round robin from reset with all four requesting
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk($sformatf("rr_grant%0d", g), 32'(bus.req_ready), 32'(1 << (g % 4)));
            cyc();
            bus.mem_ready = 1'b1;
            cyc();
            bus.mem_ready = 1'b0;
            chk($sformatf("rr_rsp%0d", g), 32'(bus.rsp_valid), 32'(1 << (g % 4)));
            cyc();
            if (g == 4) bus.req_valid = '0;
        end

        // write, requester 1; source fields scrambled after accept
        bus.req_valid      = 4'b0010;
        bus.req_addr[1]    = 8'h10;
        bus.req_wr_data[1] = 16'h1234;
        bus.req_wr_rd[1]   = 1'b1;
        #1;
        chk("wr_accept", 32'(bus.req_ready), 32'h2);
        cyc();
        bus.req_valid      = '0;
        bus.req_addr[1]    = 8'hEE;
        bus.req_wr_data[1] = 16'h0;
        bus.req_wr_rd[1]   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wr_addr%0d", i),  32'(bus.mem_addr),    32'h10);
            chk($sformatf("wr_data%0d", i),  32'(bus.mem_wr_data), 32'h1234);
            chk($sformatf("wr_wrrd%0d", i),  32'(bus.mem_wr_rd),   32'h1);
            chk($sformatf("wr_mv%0d", i),    32'(bus.mem_valid),   32'h1);
            if (i < 2) cyc();
        end
        bus.mem_ready   = 1'b1;
        bus.mem_rd_data = 16'hFFFF;
        cyc();
        bus.mem_ready   = 1'b0;
        bus.mem_rd_data = '0;
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("wr_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        chk("wr_rsp_err",   32'(bus.rsp_err),   32'h0);
        cyc();

        // mem_ready on the expiring cycle completes normally
        bus.req_valid   = 4'b0001;
        bus.req_addr[0] = 8'h20;
        #1;
        chk("ex_accept", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = '0;
        for (int i = 0; i < 7; i++) cyc();
        chk("ex_mv_8th", 32'(bus.mem_valid), 32'h1);
        bus.mem_ready   = 1'b1;
        bus.mem_rd_data = 16'hA5A5;
        cyc();
        bus.mem_ready   = 1'b0;
        bus.mem_rd_data = '0;
        chk("ex_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("ex_rsp_err",   32'(bus.rsp_err),   32'h0);
        chk("ex_rsp_rdata", 32'(bus.rsp_rdata), 32'hA5A5);
        cyc();

        // mem_ready while IDLE is ignored
        bus.mem_ready = 1'b1;
        cyc();
        cyc();
        bus.mem_ready = 1'b0;
        chk("idle_mr_busy", 32'(bus.busy),      32'h0);
        chk("idle_mr_rsp",  32'(bus.rsp_valid), 32'h0);

        // timeout, requester 3, mem_ready never comes
        bus.req_valid   = 4'b1000;
        bus.req_addr[3] = 8'h55;
        #1;
        chk("to_accept", 32'(bus.req_ready), 32'h8);
        cyc();
        bus.req_valid = '0;
        n_mv    = 0;
        got_rsp = 1'b0;
        for (int i = 0; i < 20 && !got_rsp; i++) begin
            if (bus.rsp_valid != '0) got_rsp = 1'b1;
            else begin
                if (bus.mem_valid) n_mv++;
                cyc();
            end
        end
        chk("to_rsp_seen",  32'(got_rsp),       32'h1);
        chk("to_mv_cycles", 32'(n_mv),          32'd8);
        chk("to_rsp_valid", 32'(bus.rsp_valid), 32'h8);
        chk("to_rsp_err",   32'(bus.rsp_err),   32'h1);
        chk("to_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        cyc();

        // reset two cycles into BUSY abandons the transaction
        bus.req_valid   = 4'b0100;
        bus.req_addr[2] = 8'h77;
        #1;
        chk("rb_accept", 32'(bus.req_ready), 32'h4);
        cyc();
        bus.req_valid = '0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rb_mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("rb_busy",      32'(bus.busy),      32'h0);
        saw_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.rsp_valid != '0) saw_rsp = 1'b1;
            cyc();
        end
        chk("rb_no_rsp", 32'(saw_rsp), 32'h0);
        bus.req_valid = '1;
        #1;
        chk("rb_next_grant", 32'(bus.req_ready), 32'h1);
        bus.req_valid = '0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
